mx_row_feeder: RTL and testbench

//  Upstream driver for one row of input-skipping MX cells. Accepts parallel 8-bit activations and 8-bit

---
 rtl/mx_feeder_pkg.sv | 30 +++
 rtl/mx_row_feeder_if.sv | 31 +++
 rtl/mx_act_serializer.sv | 77 +++++++
 rtl/mx_row_feeder.sv | 233 +++++++++++++++++++++++
 tb/tb_mx_row_feeder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mx_feeder_pkg.sv
// ---------------------------------------------------------------------------
// mx_feeder_pkg
// Shared constants and helpers for the MX cell-row feeder.
//   ACT_W      activation bits per lane, serialised LSB first
//   NUM_SLOTS  MAC slots per MX cell (the cell row is built for exactly 4)
//   WEIGHT_W   shared weight width
//   CNT_W      width of the bit / chunk counter
//   state_t    FSM encoding: ST_IDLE / ST_LOAD_W / ST_STREAM
//   slot_onehot(slot) -> one-hot slot vector for clr/mac_en
// ---------------------------------------------------------------------------
package mx_feeder_pkg;

    localparam int ACT_W     = 8;
    localparam int NUM_SLOTS = 4;
    localparam int WEIGHT_W  = 8;
    localparam int CNT_W     = $clog2(ACT_W);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOAD_W = 2'd1;
    localparam state_t ST_STREAM = 2'd2;

    typedef logic [$clog2(NUM_SLOTS)-1:0] slot_t;

    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input slot_t slot);
        return NUM_SLOTS'(1) << slot;
    endfunction

endpackage

// File: rtl/mx_row_feeder_if.sv
// ---------------------------------------------------------------------------
// mx_row_feeder_if
// Input handshake bundle of the row feeder: parallel activations and the
// shared weight, each on its own valid/ready pair.
//   act_valid / act_ready / act_data[DATA_WIDTH*8]  activation word
//   w_valid   / w_ready   / w_data[8]               shared weight
// Modports: master = producer of activations/weights, slave = the feeder.
// ---------------------------------------------------------------------------
interface mx_row_feeder_if #(
    parameter int DATA_WIDTH = 2
);
    import mx_feeder_pkg::*;

    logic                        act_valid;
    logic                        act_ready;
    logic [DATA_WIDTH*ACT_W-1:0] act_data;
    logic                        w_valid;
    logic                        w_ready;
    logic [WEIGHT_W-1:0]         w_data;

    modport master (
        output act_valid, act_data, w_valid, w_data,
        input  act_ready, w_ready
    );

    modport slave (
        input  act_valid, act_data, w_valid, w_data,
        output act_ready, w_ready
    );

endinterface

// File: rtl/mx_act_serializer.sv
// ---------------------------------------------------------------------------
// mx_act_serializer
// Shift register shared by activation streaming and weight loading.
//   Activation mode: DATA_WIDTH independent 8-bit lanes, each shifted right
//   by one per cycle; ser_o[i] is the LSB of lane i.
//   Chunk mode: the weight sits in the low 8 bits and the whole register
//   shifts right by DATA_WIDTH; ser_o is the lowest DATA_WIDTH-bit chunk.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load_act_i        parallel load of act_data_i (highest priority)
//   load_w_i          parallel load of w_data_i
//   shift_i           advance by one bit (activation) or one chunk (weight)
//   chunk_mode_i      1 = weight chunk mode, 0 = per-lane activation mode
//   act_data_i        DATA_WIDTH*8 activation word
//   w_data_i          8-bit shared weight
//   ser_o             current serial bit per lane / current weight chunk
// ---------------------------------------------------------------------------
module mx_act_serializer
    import mx_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_act_i,
    input  logic                        load_w_i,
    input  logic                        shift_i,
    input  logic                        chunk_mode_i,
    input  logic [DATA_WIDTH*ACT_W-1:0] act_data_i,
    input  logic [WEIGHT_W-1:0]         w_data_i,
    output logic [DATA_WIDTH-1:0]       ser_o
);

    localparam int SR_W = DATA_WIDTH * ACT_W;

    logic [SR_W-1:0] shift_q;
    logic [SR_W-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (load_act_i) begin
            shift_d = act_data_i;
        end else if (load_w_i) begin
            shift_d = SR_W'(w_data_i);
        end else if (shift_i) begin
            if (chunk_mode_i) begin
                shift_d = shift_q >> DATA_WIDTH;
            end else begin
                // Each lane shifts on its own so lane bits never leak into
                // the neighbouring lane.
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    shift_d[i*ACT_W +: ACT_W] = {1'b0, shift_q[i*ACT_W+1 +: ACT_W-1]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    always_comb begin
        ser_o = '0;
        if (chunk_mode_i) begin
            ser_o = shift_q[DATA_WIDTH-1:0];
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                ser_o[i] = shift_q[i*ACT_W];
            end
        end
    end

endmodule

// File: rtl/mx_row_feeder.sv
// ---------------------------------------------------------------------------
// mx_row_feeder
// Upstream driver for one row of input-skipping MX cells. Accepts parallel
// activations and a shared weight over valid/ready and produces the cell-row
// input bundle: bit-serial data, zero flags, slot pulses, mac_en, the
// update_w weight-shift window and the sel toggle.
// Optional feature: define ZERO_SKIP_EN to drive per-lane zero flags;
// without it zero_inputs_out is tied to 0 and no zero-detect is built.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   feed_if (slave)       act_valid/ready/data, w_valid/ready/data
//   dataflow_out          serial bit per lane, or weight chunk in LOAD_W
//   zero_inputs_out       1 = lane activation is zero (ZERO_SKIP_EN only)
//   clr_and_plus_one_o    one-hot slot pulse on the first bit of a word
//   mac_en_o              one-hot slot, high for all bits of a word
//   update_w_o            high while the weight is being shifted in
//   sel_out               toggles once per activation
//   busy                  FSM not idle
// ---------------------------------------------------------------------------
module mx_row_feeder
    import mx_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mx_row_feeder_if.slave        feed_if,
    output logic [DATA_WIDTH-1:0] dataflow_out,
    output logic [DATA_WIDTH-1:0] zero_inputs_out,
    output logic [NUM_SLOTS-1:0]  clr_and_plus_one_o,
    output logic [NUM_SLOTS-1:0]  mac_en_o,
    output logic                  update_w_o,
    output logic                  sel_out,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(ACT_W - 1);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(WEIGHT_W / DATA_WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    slot_t            slot_q, slot_d;
    logic             sel_q, sel_d;

    logic                  load_act, load_w, shift_en;
    logic                  act_fire, w_fire;
    logic                  at_last_bit, at_last_chunk;
    logic [DATA_WIDTH-1:0] ser_data;
    logic [DATA_WIDTH-1:0] zero_flags;

    // ---------------- handshake ----------------
    assign at_last_bit   = (state_q == ST_STREAM) && (bit_cnt_q == LAST_BIT);
    assign at_last_chunk = (state_q == ST_LOAD_W) && (bit_cnt_q == LAST_CHUNK);

    // Weight has priority: an activation is only taken when no weight is
    // offered. A pending activation is also taken on the last weight chunk so
    // it streams straight after LOAD_W with no bubble.
    assign feed_if.w_ready   = !reset && ((state_q == ST_IDLE) || at_last_bit);
    assign feed_if.act_ready = !reset && !feed_if.w_valid &&
                               ((state_q == ST_IDLE) || at_last_bit || at_last_chunk);

    assign act_fire = feed_if.act_valid && feed_if.act_ready;
    assign w_fire   = feed_if.w_valid && feed_if.w_ready;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q <= '0;
            slot_q    <= '0;
            sel_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            slot_q    <= slot_d;
            sel_q     <= sel_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        slot_d    = slot_q;
        sel_d     = sel_q;
        load_act  = 1'b0;
        load_w    = 1'b0;
        shift_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_fire) begin
                    state_d   = ST_LOAD_W;
                    bit_cnt_d = '0;
                    slot_d    = '0;
                    sel_d     = 1'b0;
                    load_w    = 1'b1;
                end else if (act_fire) begin
                    state_d   = ST_STREAM;
                    bit_cnt_d = '0;
                    sel_d     = !sel_q;
                    load_act  = 1'b1;
                end
            end

            ST_LOAD_W: begin
                if (bit_cnt_q == LAST_CHUNK) begin
                    bit_cnt_d = '0;
                    if (act_fire) begin
                        state_d  = ST_STREAM;
                        sel_d    = !sel_q;
                        load_act = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    shift_en  = 1'b1;
                end
            end

            ST_STREAM: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    slot_d    = slot_q + slot_t'(1);
                    if (act_fire) begin
                        sel_d    = !sel_q;
                        load_act = 1'b1;
                    end else if (w_fire) begin
                        state_d = ST_LOAD_W;
                        slot_d  = '0;
                        sel_d   = 1'b0;
                        load_w  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    shift_en  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    mx_act_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk          (clk),
        .reset        (reset),
        .load_act_i   (load_act),
        .load_w_i     (load_w),
        .shift_i      (shift_en),
        .chunk_mode_i (state_q == ST_LOAD_W),
        .act_data_i   (feed_if.act_data),
        .w_data_i     (feed_if.w_data),
        .ser_o        (ser_data)
    );

`ifdef ZERO_SKIP_EN
    logic [DATA_WIDTH-1:0] zero_q, zero_d;

    // Flags are captured with the word so they are valid from its first bit.
    always_comb begin
        zero_d = zero_q;
        if (load_act) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                zero_d[i] = (feed_if.act_data[i*ACT_W +: ACT_W] == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= '0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero_flags = zero_q;
`else
    assign zero_flags = '0;
`endif

    // ---------------- FSM: outputs ----------------
    // sel_out keeps its level through idle gaps; it is cleared by reset and
    // by a weight load, which the cell mirrors on update_w.
    assign sel_out = sel_q;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        dataflow_out       = '0;
        zero_inputs_out    = '0;
        clr_and_plus_one_o = '0;
        mac_en_o           = '0;
        update_w_o         = 1'b0;

        case (state_q)
            ST_LOAD_W: begin
                update_w_o   = 1'b1;
                dataflow_out = ser_data;
            end

            ST_STREAM: begin
                dataflow_out    = ser_data;
                zero_inputs_out = zero_flags;
                mac_en_o        = slot_onehot(slot_q);
                if (bit_cnt_q == '0) begin
                    clr_and_plus_one_o = slot_onehot(slot_q);
                end
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mx_row_feeder.sv
// ---------------------------------------------------------------------------
// tb_mx_row_feeder
// Directed bench for mx_row_feeder with DATA_WIDTH = 2. Expected values are
// written by hand (slot one-hots, sel levels, weight chunks) or taken from
// the bit definitions of the stimulus word.
// ---------------------------------------------------------------------------
module tb_mx_row_feeder;

    localparam int DW = 2;

    logic          clk;
    logic          reset;
    logic [DW-1:0] dataflow_out;
    logic [DW-1:0] zero_inputs_out;
    logic [3:0]    clr_and_plus_one_o;
    logic [3:0]    mac_en_o;
    logic          update_w_o;
    logic          sel_out;
    logic          busy;

    int checks = 0;
    int errors = 0;

    mx_row_feeder_if #(.DATA_WIDTH(DW)) feed_if ();

    mx_row_feeder #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .feed_if            (feed_if),
        .dataflow_out       (dataflow_out),
        .zero_inputs_out    (zero_inputs_out),
        .clr_and_plus_one_o (clr_and_plus_one_o),
        .mac_en_o           (mac_en_o),
        .update_w_o         (update_w_o),
        .sel_out            (sel_out),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] df, input logic [1:0] zf,
                              input logic [3:0] clr, input logic [3:0] mac,
                              input logic upd, input logic sel, input logic bsy);
        check({tag, ".df"},   32'(dataflow_out),       32'(df));
        check({tag, ".zero"}, 32'(zero_inputs_out),    32'(zf));
        check({tag, ".clr"},  32'(clr_and_plus_one_o), 32'(clr));
        check({tag, ".mac"},  32'(mac_en_o),           32'(mac));
        check({tag, ".updw"}, 32'(update_w_o),         32'(upd));
        check({tag, ".sel"},  32'(sel_out),            32'(sel));
        check({tag, ".busy"}, 32'(busy),               32'(bsy));
    endtask

    task automatic expect_idle(input string tag, input logic sel);
        expect_out(tag, 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, sel, 1'b0);
    endtask

    // Checks the eight bit cycles of one word. On the last bit it presents
    // the next request (activation and/or weight) and checks the ready pair.
    task automatic stream_word(input string tag, input logic [15:0] word,
                               input logic [3:0] slot_oh, input logic sel,
                               input logic [15:0] nxt_word, input logic nxt_act,
                               input logic nxt_w, input logic [7:0] nxt_wdata);
        logic [1:0] zf;
`ifdef ZERO_SKIP_EN
        zf = {word[15:8] == 8'h00, word[7:0] == 8'h00};
`else
        zf = 2'b00;
`endif
        for (int c = 0; c < 8; c++) begin
            expect_out($sformatf("%s.b%0d", tag, c), {word[8+c], word[c]}, zf,
                       (c == 0) ? slot_oh : 4'b0000, slot_oh, 1'b0, sel, 1'b1);
            if (c == 7) begin
                feed_if.act_valid = nxt_act;
                feed_if.act_data  = nxt_word;
                feed_if.w_valid   = nxt_w;
                feed_if.w_data    = nxt_wdata;
                #1;
                check({tag, ".act_ready_last"}, 32'(feed_if.act_ready), 32'(!nxt_w));
                check({tag, ".w_ready_last"},   32'(feed_if.w_ready),   32'd1);
            end else begin
                check($sformatf("%s.act_ready_b%0d", tag, c), 32'(feed_if.act_ready), 32'd0);
                check($sformatf("%s.w_ready_b%0d", tag, c),   32'(feed_if.w_ready),   32'd0);
            end
            tick();
        end
    endtask

    // Four LOAD_W cycles, lowest weight chunk first.
    task automatic load_weight(input string tag, input logic [7:0] w, input logic [1:0] chunks [4]);
        feed_if.w_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            expect_out($sformatf("%s.c%0d", tag, c), chunks[c], 2'b00, 4'b0000, 4'b0000,
                       1'b1, 1'b0, 1'b1);
            check($sformatf("%s.w_ready_c%0d", tag, c), 32'(feed_if.w_ready), 32'd0);
            tick();
        end
        check({tag, ".wdata_held"}, 32'(feed_if.w_data), 32'(w));
    endtask

    logic [1:0] chunks_c6 [4];
    logic [1:0] chunks_1b [4];

    initial begin
        // 8'hC6 = 11_00_01_10 -> 2,1,0,3 ; 8'h1B = 00_01_10_11 -> 3,2,1,0
        chunks_c6 = '{2'd2, 2'd1, 2'd0, 2'd3};
        chunks_1b = '{2'd3, 2'd2, 2'd1, 2'd0};

        // ---- 1: reset with a pending activation ----
        reset             = 1'b1;
        feed_if.act_valid = 1'b1;
        feed_if.act_data  = 16'h01A5;
        feed_if.w_valid   = 1'b0;
        feed_if.w_data    = 8'h00;
        tick();
        tick();
        expect_idle("t1_reset", 1'b0);
        check("t1_act_ready_in_reset", 32'(feed_if.act_ready), 32'd0);
        check("t1_w_ready_in_reset",   32'(feed_if.w_ready),   32'd0);
        reset             = 1'b0;
        feed_if.act_valid = 1'b0;
        #1;
        check("t1_act_ready_idle", 32'(feed_if.act_ready), 32'd1);
        check("t1_w_ready_idle",   32'(feed_if.w_ready),   32'd1);

        // ---- 2: single word 16'h01A5 from slot 0 ----
        feed_if.act_valid = 1'b1;
        feed_if.act_data  = 16'h01A5;
        tick();
        stream_word("t2", 16'h01A5, 4'b0001, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00);
        expect_idle("t2_idle", 1'b1);

        // ---- 3: five back-to-back words; slot continues from 1 and wraps ----
        feed_if.act_valid = 1'b1;
        feed_if.act_data  = 16'h8001;
        tick();
        stream_word("t3_w0", 16'h8001, 4'b0010, 1'b0, 16'hFF00, 1'b1, 1'b0, 8'h00);
        stream_word("t3_w1", 16'hFF00, 4'b0100, 1'b1, 16'h0000, 1'b1, 1'b0, 8'h00);
        stream_word("t3_w2", 16'h0000, 4'b1000, 1'b0, 16'h5A3C, 1'b1, 1'b0, 8'h00);
        stream_word("t3_w3", 16'h5A3C, 4'b0001, 1'b1, 16'h0137, 1'b1, 1'b0, 8'h00);
        stream_word("t3_w4", 16'h0137, 4'b0010, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        expect_idle("t3_idle", 1'b0);

        // ---- 4: weight and activation together; weight wins ----
        feed_if.w_valid   = 1'b1;
        feed_if.w_data    = 8'hC6;
        feed_if.act_valid = 1'b1;
        feed_if.act_data  = 16'h01A5;
        #1;
        check("t4_act_ready_stall", 32'(feed_if.act_ready), 32'd0);
        check("t4_w_ready",         32'(feed_if.w_ready),   32'd1);
        tick();
        load_weight("t4_lw", 8'hC6, chunks_c6);
        stream_word("t4_act", 16'h01A5, 4'b0001, 1'b1, 16'h0037, 1'b1, 1'b0, 8'h00);

        // ---- 5: zero flags, lane1 zero ----
        stream_word("t5", 16'h0037, 4'b0010, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        expect_idle("t5_idle", 1'b0);

        // ---- 6: reset in the middle of a word ----
        feed_if.act_valid = 1'b1;
        feed_if.act_data  = 16'hFFFF;
        tick();
        feed_if.act_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            expect_out($sformatf("t6_part.b%0d", c), 2'b11, 2'b00,
                       (c == 0) ? 4'b0100 : 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b1);
            if (c == 3) reset = 1'b1;
            tick();
        end
        expect_idle("t6_after_reset", 1'b0);
        check("t6_act_ready_in_reset", 32'(feed_if.act_ready), 32'd0);
        reset = 1'b0;
        feed_if.act_valid = 1'b1;
        feed_if.act_data  = 16'h8001;
        tick();
        // Last bit offers both a weight and a word: weight first, word after.
        stream_word("t6_w0", 16'h8001, 4'b0001, 1'b1, 16'h00FF, 1'b1, 1'b1, 8'h1B);
        load_weight("t6_lw", 8'h1B, chunks_1b);
        stream_word("t6_w1", 16'h00FF, 4'b0001, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00);
        expect_idle("t6_idle", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
